mc_control_fsm: RTL and testbench
=================================

MC_CONTROL_FSM -- requirements
Module: mc_control_fsm

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; it SHALL have no parameters.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 opcode  in  6  IR[31:26]; sampled only in DECODE.
REQ-005 zero  in  1  ALU zero flag; used only in BRANCH.
REQ-006 mem_ready  in  1  memory completion; qualifies FETCH, MEMRD and MEMWR.
REQ-007 The mux-select outputs SHALL be: iord 1 (0=PC, 1=ALUOut address); alu_src_a 1 (0=PC, 1=A); alu_src_b 2 (00=B, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2); mem_to_reg 1 (0=ALUOut, 1=MDR); reg_dst 1 (0=rt, 1=rd); pc_src 2 (00=ALU, 01=ALUOut, 10=jump target).
REQ-008 The enable outputs SHALL be mem_rd, mem_wr, ir_wr, reg_wr, pc_en (1 each).
REQ-009 The remaining outputs SHALL be: alu_op 2 (00=add, 01=sub, 10=funct); err 1 (sticky illegal opcode); state 4 (current state, debug); instr_cnt 32 (retired instructions).

Function
REQ-010 The block SHALL use a registered Moore FSM with this state encoding: IDLE=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6, EXEC=7, RWB=8, BRANCH=9, JUMP=10, ADDIEX=11, ADDIWB=12, ERR=15; codes 13 and 14 SHALL go to ERR on the next edge.
REQ-011 Every output not listed for a state SHALL be 0 in that state.
REQ-012 IDLE: all outputs 0; next state FETCH unconditionally.
REQ-013 FETCH: mem_rd=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00. Stay while mem_ready=0. In the cycle mem_ready=1: ir_wr=1, pc_en=1, next state DECODE.
REQ-014 DECODE: alu_src_a=0, alu_src_b=11, alu_op=00. Next state by opcode: 000000->EXEC, 100011 or 101011->MEMADR, 000100->BRANCH, 000010->JUMP, 001000->ADDIEX, any other->ERR.
REQ-015 MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. Next state MEMRD if the latched opcode is 100011, else MEMWR.
REQ-016 The block SHALL latch opcode internally in DECODE; MEMADR SHALL use the latched copy, not the live input.
REQ-017 MEMRD: mem_rd=1, iord=1. Stay until mem_ready=1, then MEMWB.
REQ-018 MEMWB: reg_wr=1, reg_dst=0, mem_to_reg=1. Next state FETCH.
REQ-019 MEMWR: mem_wr=1, iord=1. Stay until mem_ready=1, then FETCH.
REQ-020 EXEC: alu_src_a=1, alu_src_b=00, alu_op=10. Next state RWB.
REQ-021 RWB: reg_wr=1, reg_dst=1, mem_to_reg=0. Next state FETCH.
REQ-022 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, pc_en=zero. Next state FETCH.
REQ-023 JUMP: pc_src=10, pc_en=1. Next state FETCH.
REQ-024 ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00. Next state ADDIWB.
REQ-025 ADDIWB: reg_wr=1, reg_dst=0, mem_to_reg=0. Next state FETCH.
REQ-026 ERR: err=1, all other outputs 0. ERR SHALL be absorbing and left only by reset.
REQ-027 pc_en and ir_wr SHALL be combinational from state and inputs (mem_ready, zero); all other outputs SHALL depend on state only.
REQ-028 instr_cnt SHALL increment by 1 on each edge where a state in {MEMWB, MEMWR with mem_ready=1, RWB, BRANCH, JUMP, ADDIWB} transitions to FETCH.
REQ-029 instr_cnt SHALL wrap from 0xFFFFFFFF to 0 and SHALL NOT increment on IDLE->FETCH.
REQ-030 Instruction latency SHALL be: R/addi 4 cycles, beq/j 3 cycles, lw 5 cycles, sw 4 cycles; each memory state that waits on mem_ready SHALL add one cycle per cycle of mem_ready=0.

Reset
REQ-031 While rst_n=0, independent of clk: state=IDLE, instr_cnt=0, err=0, latched opcode=0, and all outputs 0.
REQ-032 Assertion of rst_n mid-instruction SHALL abort the instruction, including mid-memory-wait; no enable SHALL be asserted after reset assertion.
REQ-033 The first FETCH SHALL occur in the second cycle after rst_n deasserts (IDLE, then FETCH).

Verification
REQ-034 Release reset with mem_ready=1 and opcode=000000 -> state sequence 0,1,2,7,8,1; reg_wr=1 with reg_dst=1 in the RWB cycle; instr_cnt=1 after RWB.
REQ-035 lw (100011), mem_ready low for 2 cycles in MEMRD -> MEMRD held 3 cycles with mem_rd=1 and iord=1; MEMWB has mem_to_reg=1; instr_cnt increments once.
REQ-036 beq (000100) with zero=0, then with zero=1 -> pc_en=0 in the first BRANCH cycle and pc_en=1 in the second, pc_src=01 and alu_op=01 in both.
REQ-037 opcode=111111 in DECODE -> ERR; err=1 held for 10 cycles with all enables 0; pulse rst_n low -> err=0 and state=0.
REQ-038 Assert rst_n low during a MEMWR wait -> mem_wr drops immediately without a clock edge; instr_cnt=0.
REQ-039 Preload instr_cnt to 0xFFFFFFFF via a back-door force, then retire one j (000010) -> instr_cnt=0x00000000.

Source files
------------

// File: rtl/mc_control_fsm.sv
// Multi-cycle processor control FSM (Moore). Sequences fetch, decode,
// memory, ALU, branch and jump steps, and counts retired instructions.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   opcode            IR[31:26], sampled in DECODE
//   zero              ALU zero flag, used in BRANCH
//   mem_ready         memory completion for FETCH / MEMRD / MEMWR
//   iord, alu_src_a, alu_src_b, mem_to_reg, reg_dst, pc_src   datapath mux selects
//   mem_rd, mem_wr, ir_wr, reg_wr, pc_en                      datapath enables
//   alu_op            00 add, 01 sub, 10 funct
//   err               set while in the absorbing ERR state
//   state             current state code (debug)
//   instr_cnt         retired instruction counter (wraps)
module mc_control_fsm (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  opcode,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        iord,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic        mem_to_reg,
  output logic        reg_dst,
  output logic [1:0]  pc_src,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic        ir_wr,
  output logic        reg_wr,
  output logic        pc_en,
  output logic [1:0]  alu_op,
  output logic        err,
  output logic [3:0]  state,
  output logic [31:0] instr_cnt
);

  localparam int unsigned OPC_W = 6;
  localparam int unsigned CNT_W = 32;

  localparam logic [OPC_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPC_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OPC_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OPC_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPC_W-1:0] OP_J     = 6'b000010;
  localparam logic [OPC_W-1:0] OP_ADDI  = 6'b001000;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_RWB    = 4'd8,
    S_BRANCH = 4'd9,
    S_JUMP   = 4'd10,
    S_ADDIEX = 4'd11,
    S_ADDIWB = 4'd12,
    S_ERR    = 4'd15
  } state_e;

  state_e             state_q, state_d;
  logic [OPC_W-1:0]   opc_q, opc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               retire;

  // State, latched opcode and retire counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      opc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      opc_q   <= opc_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and output decode; ir_wr/pc_en also see mem_ready/zero
  always_comb begin
    state_d    = state_q;
    opc_d      = opc_q;
    cnt_d      = cnt_q;
    retire     = 1'b0;
    iord       = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    mem_to_reg = 1'b0;
    reg_dst    = 1'b0;
    pc_src     = 2'b00;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    ir_wr      = 1'b0;
    reg_wr     = 1'b0;
    pc_en      = 1'b0;
    alu_op     = 2'b00;
    err        = 1'b0;

    case (state_q)
      S_IDLE: state_d = S_FETCH;

      S_FETCH: begin
        mem_rd    = 1'b1;
        alu_src_b = 2'b01;
        if (mem_ready) begin
          ir_wr   = 1'b1;
          pc_en   = 1'b1;
          state_d = S_DECODE;
        end
      end

      S_DECODE: begin
        alu_src_b = 2'b11;
        opc_d     = opcode;
        case (opcode)
          OP_RTYPE:      state_d = S_EXEC;
          OP_LW, OP_SW:  state_d = S_MEMADR;
          OP_BEQ:        state_d = S_BRANCH;
          OP_J:          state_d = S_JUMP;
          OP_ADDI:       state_d = S_ADDIEX;
          default:       state_d = S_ERR;
        endcase
      end

      // Uses the opcode captured in DECODE; the live IR bits may have moved on
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (opc_q == OP_LW) ? S_MEMRD : S_MEMWR;
      end

      S_MEMRD: begin
        mem_rd = 1'b1;
        iord   = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end

      S_MEMWB: begin
        reg_wr     = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end

      S_MEMWR: begin
        mem_wr = 1'b1;
        iord   = 1'b1;
        if (mem_ready) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end

      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        state_d   = S_RWB;
      end

      S_RWB: begin
        reg_wr  = 1'b1;
        reg_dst = 1'b1;
        retire  = 1'b1;
        state_d = S_FETCH;
      end

      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b01;
        pc_src    = 2'b01;
        pc_en     = zero;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end

      S_JUMP: begin
        pc_src  = 2'b10;
        pc_en   = 1'b1;
        retire  = 1'b1;
        state_d = S_FETCH;
      end

      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = S_ADDIWB;
      end

      S_ADDIWB: begin
        reg_wr  = 1'b1;
        retire  = 1'b1;
        state_d = S_FETCH;
      end

      // Absorbing; only reset leaves
      S_ERR: err = 1'b1;

      // Unused codes 13/14 drop into ERR with outputs held low
      default: state_d = S_ERR;
    endcase

    if (retire) cnt_d = cnt_q + CNT_W'(1);
  end

  assign state     = state_q;
  assign instr_cnt = cnt_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm: walks R, lw, beq, sw, addi, j and an
// illegal opcode, checking state, control vector and retire count.
module tb_mc_control_fsm;

  logic        clk;
  logic        rst_n;
  logic [5:0]  opcode;
  logic        zero;
  logic        mem_ready;
  logic        iord, alu_src_a, mem_to_reg, reg_dst;
  logic [1:0]  alu_src_b, pc_src, alu_op;
  logic        mem_rd, mem_wr, ir_wr, reg_wr, pc_en, err;
  logic [3:0]  state;
  logic [31:0] instr_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  mc_control_fsm dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .iord       (iord),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .mem_to_reg (mem_to_reg),
    .reg_dst    (reg_dst),
    .pc_src     (pc_src),
    .mem_rd     (mem_rd),
    .mem_wr     (mem_wr),
    .ir_wr      (ir_wr),
    .reg_wr     (reg_wr),
    .pc_en      (pc_en),
    .alu_op     (alu_op),
    .err        (err),
    .state      (state),
    .instr_cnt  (instr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed control vector: enables, selects, alu_op, err
  logic [15:0] ctrl;
  assign ctrl = {mem_rd, mem_wr, ir_wr, reg_wr, pc_en, iord, alu_src_a,
                 alu_src_b, mem_to_reg, reg_dst, pc_src, alu_op, err};

  function automatic logic [15:0] mk(
    input logic rd, input logic wr, input logic irw, input logic rw,
    input logic pce, input logic io, input logic asa, input logic [1:0] asb,
    input logic m2r, input logic rdst, input logic [1:0] psrc,
    input logic [1:0] aop, input logic e);
    return {rd, wr, irw, rw, pce, io, asa, asb, m2r, rdst, psrc, aop, e};
  endfunction

  localparam logic [15:0] C_IDLE   = 16'h0000;
  localparam logic [15:0] C_FETCHW = mk(1,0,0,0,0,0,0,2'b01,0,0,2'b00,2'b00,0);
  localparam logic [15:0] C_FETCHR = mk(1,0,1,0,1,0,0,2'b01,0,0,2'b00,2'b00,0);
  localparam logic [15:0] C_DECODE = mk(0,0,0,0,0,0,0,2'b11,0,0,2'b00,2'b00,0);
  localparam logic [15:0] C_MEMADR = mk(0,0,0,0,0,0,1,2'b10,0,0,2'b00,2'b00,0);
  localparam logic [15:0] C_MEMRD  = mk(1,0,0,0,0,1,0,2'b00,0,0,2'b00,2'b00,0);
  localparam logic [15:0] C_MEMWB  = mk(0,0,0,1,0,0,0,2'b00,1,0,2'b00,2'b00,0);
  localparam logic [15:0] C_MEMWR  = mk(0,1,0,0,0,1,0,2'b00,0,0,2'b00,2'b00,0);
  localparam logic [15:0] C_EXEC   = mk(0,0,0,0,0,0,1,2'b00,0,0,2'b00,2'b10,0);
  localparam logic [15:0] C_RWB    = mk(0,0,0,1,0,0,0,2'b00,0,1,2'b00,2'b00,0);
  localparam logic [15:0] C_BR0    = mk(0,0,0,0,0,0,1,2'b00,0,0,2'b01,2'b01,0);
  localparam logic [15:0] C_BR1    = mk(0,0,0,0,1,0,1,2'b00,0,0,2'b01,2'b01,0);
  localparam logic [15:0] C_JUMP   = mk(0,0,0,0,1,0,0,2'b00,0,0,2'b10,2'b00,0);
  localparam logic [15:0] C_ADDIWB = mk(0,0,0,1,0,0,0,2'b00,0,0,2'b00,2'b00,0);
  localparam logic [15:0] C_ERR    = mk(0,0,0,0,0,0,0,2'b00,0,0,2'b00,2'b00,1);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic check_st(input string tag, input logic [3:0] st, input logic [15:0] ctl);
    check({tag, ".state"}, 32'(state), 32'(st));
    check({tag, ".ctrl"},  32'(ctrl),  32'(ctl));
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    opcode    = 6'b000000;
    zero      = 1'b0;
    mem_ready = 1'b1;
    #2;
    check_st("reset", 4'd0, C_IDLE);
    check("reset.cnt", instr_cnt, 32'd0);

    // R-type: 0,1,2,7,8,1
    @(negedge clk);
    rst_n = 1'b1;
    check_st("r.idle", 4'd0, C_IDLE);
    step(); check_st("r.fetch", 4'd1, C_FETCHR);
    step(); check_st("r.decode", 4'd2, C_DECODE);
    step(); check_st("r.exec", 4'd7, C_EXEC);
    step(); check_st("r.rwb", 4'd8, C_RWB);
    check("r.cnt_pre", instr_cnt, 32'd0);
    step(); check_st("r.fetch2", 4'd1, C_FETCHR);
    check("r.cnt", instr_cnt, 32'd1);

    // lw with two wait cycles; opcode changed after DECODE to test latch
    opcode = 6'b100011;
    step(); check_st("lw.decode", 4'd2, C_DECODE);
    step(); check_st("lw.memadr", 4'd3, C_MEMADR);
    opcode = 6'b101011;
    mem_ready = 1'b0;
    step(); check_st("lw.memrd1", 4'd4, C_MEMRD);
    step(); check_st("lw.memrd2", 4'd4, C_MEMRD);
    step(); check_st("lw.memrd3", 4'd4, C_MEMRD);
    mem_ready = 1'b1;
    step(); check_st("lw.memwb", 4'd5, C_MEMWB);
    check("lw.cnt_pre", instr_cnt, 32'd1);
    step(); check_st("lw.fetch", 4'd1, C_FETCHR);
    check("lw.cnt", instr_cnt, 32'd2);

    // beq not taken, then taken
    opcode = 6'b000100;
    zero   = 1'b0;
    step(); check_st("beq0.decode", 4'd2, C_DECODE);
    step(); check_st("beq0.branch", 4'd9, C_BR0);
    step(); check("beq0.cnt", instr_cnt, 32'd3);
    zero = 1'b1;
    step(); check_st("beq1.decode", 4'd2, C_DECODE);
    step(); check_st("beq1.branch", 4'd9, C_BR1);
    step(); check_st("beq1.fetch", 4'd1, C_FETCHR);
    check("beq1.cnt", instr_cnt, 32'd4);
    zero = 1'b0;

    // sw, reset asserted during the MEMWR wait
    opcode = 6'b101011;
    step(); check_st("sw.decode", 4'd2, C_DECODE);
    step(); check_st("sw.memadr", 4'd3, C_MEMADR);
    mem_ready = 1'b0;
    step(); check_st("sw.memwr1", 4'd6, C_MEMWR);
    step(); check_st("sw.memwr2", 4'd6, C_MEMWR);
    #2 rst_n = 1'b0;
    #1;
    check_st("sw.rst", 4'd0, C_IDLE);
    check("sw.rst.cnt", instr_cnt, 32'd0);
    @(negedge clk);
    rst_n     = 1'b1;
    mem_ready = 1'b1;

    // addi after reset
    step(); check_st("addi.fetch", 4'd1, C_FETCHR);
    opcode = 6'b001000;
    step(); check_st("addi.decode", 4'd2, C_DECODE);
    step(); check_st("addi.ex", 4'd11, C_MEMADR);
    step(); check_st("addi.wb", 4'd12, C_ADDIWB);
    step(); check("addi.cnt", instr_cnt, 32'd1);

    // FETCH stall, then counter wrap on j
    mem_ready = 1'b0;
    #1 check_st("stall.fetch", 4'd1, C_FETCHW);
    step(); check_st("stall.hold", 4'd1, C_FETCHW);
    force dut.cnt_q = 32'hFFFF_FFFF;
    #1 release dut.cnt_q;
    #1 check("j.preload", instr_cnt, 32'hFFFF_FFFF);
    mem_ready = 1'b1;
    opcode    = 6'b000010;
    #1 check_st("j.fetch", 4'd1, C_FETCHR);
    step(); check_st("j.decode", 4'd2, C_DECODE);
    step(); check_st("j.jump", 4'd10, C_JUMP);
    step(); check_st("j.fetch2", 4'd1, C_FETCHR);
    check("j.wrap", instr_cnt, 32'h0000_0000);

    // Illegal opcode: absorbing ERR
    opcode = 6'b111111;
    step(); check_st("err.decode", 4'd2, C_DECODE);
    step();
    for (int i = 0; i < 10; i++) begin
      check_st($sformatf("err.hold%0d", i), 4'd15, C_ERR);
      mem_ready = i[0];
      zero      = ~i[0];
      opcode    = 6'b000000;
      step();
    end
    rst_n = 1'b0;
    #1;
    check_st("err.rst", 4'd0, C_IDLE);
    check("err.rst.cnt", instr_cnt, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(); check("err.refetch", 32'(state), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
